// File: rtl/neosd_pkg.sv
// Shared constants for the NEOSD Wishbone interface slice.
// Holds the register address map, the INFO identification fields, the
// FSTAT sticky-bit positions and a helper that assembles the INFO word.
package neosd_pkg;

  localparam logic [7:0] ADDR_INFO  = 8'h00;
  localparam logic [7:0] ADDR_CTRL  = 8'h04;
  localparam logic [7:0] ADDR_FLAGS = 8'h08;
  localparam logic [7:0] ADDR_MASK  = 8'h0C;
  localparam logic [7:0] ADDR_DATA  = 8'h10;
  localparam logic [7:0] ADDR_FSTAT = 8'h14;

  localparam logic [15:0] INFO_MAGIC   = 16'hE05D;
  localparam logic [7:0]  INFO_VERSION = 8'h20;

  localparam int unsigned FSTAT_UNF = 30;
  localparam int unsigned FSTAT_ERR = 31;

  // INFO = magic | log2(fifo depth) | version
  function automatic logic [31:0] info_word(input int unsigned aw);
    return {INFO_MAGIC, 8'(aw), INFO_VERSION};
  endfunction

endpackage

// File: rtl/neosd_fifo.sv
// First-word-fall-through FIFO used for both the TX and RX data paths.
// Ports:
//   clk_i, rstn_i      clock, asynchronous active-low reset
//   clear_i            synchronous flush of pointers and level
//   push_i, wdata_i    write side (ignored while full)
//   pop_i, rdata_o     read side, rdata_o is the current head word (ignored while empty)
//   level_o            number of stored words, log2(DEPTH)+1 bits
//   empty_o, full_o    status
module neosd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  // Gating by empty makes push+pop on an empty FIFO a plain push.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i  & ~empty_o;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign level_o = level_q;
  assign rdata_o = mem[rptr_q];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (!do_push && do_pop) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/neosd_wbif.sv
// Wishbone (pipelined) register interface of the NEOSD SD controller.
// Ports:
//   clk_i, rstn_i                  clock, asynchronous active-low reset
//   wb_cyc_i/stb_i/we_i/adr_i/
//   dat_i/sel_i                    Wishbone request
//   wb_ack_o/stall_o/dat_o         Wishbone response (ack and data registered)
//   irq_evt_i                      level status from SD FSMs, rising edge sets a flag
//   irq_o                          OR of (FLAGS & MASK)
//   ctrl_o                         CTRL register
//   tx_data_o/valid_o/ready_i      TX FIFO read side
//   rx_data_i/valid_i/ready_o      RX FIFO write side
module neosd_wbif
  import neosd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned NIRQ       = 5
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [7:0]      wb_adr_i,
  input  logic [31:0]     wb_dat_i,
  input  logic [3:0]      wb_sel_i,
  output logic            wb_ack_o,
  output logic            wb_stall_o,
  output logic [31:0]     wb_dat_o,
  input  logic [NIRQ-1:0] irq_evt_i,
  output logic            irq_o,
  output logic [15:0]     ctrl_o,
  output logic [31:0]     tx_data_o,
  output logic            tx_valid_o,
  input  logic            tx_ready_i,
  input  logic [31:0]     rx_data_i,
  input  logic            rx_valid_i,
  output logic            rx_ready_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic            acc, wr, rd;
  logic [15:0]     lane_mask;
  logic [15:0]     ctrl_q;
  logic [NIRQ-1:0] flags_q, mask_q, evt_q, w1c, mask_nxt;
  logic            unf_q, err_q, flush_q;
  logic [31:0]     rdata;

  logic            tx_push, tx_pop, tx_empty, tx_full;
  logic            rx_push, rx_pop, rx_empty, rx_full;
  logic [31:0]     rx_head;
  logic [AW:0]     tx_level, rx_level;

  assign wb_stall_o = tx_full & wb_stb_i & wb_we_i & (wb_adr_i == ADDR_DATA);
  assign acc = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  assign wr  = acc & wb_we_i;
  assign rd  = acc & ~wb_we_i;

  assign lane_mask = {{8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign w1c = (wr && wb_adr_i == ADDR_FLAGS) ? wb_dat_i[NIRQ-1:0] : '0;

  always_comb begin
    mask_nxt = mask_q;
    if (wr && wb_adr_i == ADDR_MASK)
      mask_nxt = (mask_q & ~lane_mask[NIRQ-1:0]) | (wb_dat_i[NIRQ-1:0] & lane_mask[NIRQ-1:0]);
  end

  assign tx_push = wr & (wb_adr_i == ADDR_DATA) & (wb_sel_i == 4'hF);
  assign tx_pop  = tx_valid_o & tx_ready_i;
  assign rx_push = rx_valid_i & rx_ready_o;
  assign rx_pop  = rd & (wb_adr_i == ADDR_DATA) & ~rx_empty;

  assign tx_valid_o = ~tx_empty;
  assign rx_ready_o = ~rx_full;
  assign ctrl_o     = ctrl_q;
  assign irq_o      = |(flags_q & mask_q);

  always_comb begin
    rdata = '0;
    unique case (wb_adr_i)
      ADDR_INFO:  rdata = info_word(AW);
      ADDR_CTRL:  rdata = {16'h0000, ctrl_q};
      ADDR_FLAGS: rdata = 32'(flags_q);
      ADDR_MASK:  rdata = 32'(mask_q);
      ADDR_DATA:  rdata = rx_empty ? '0 : rx_head;
      ADDR_FSTAT: rdata = {err_q, unf_q, 5'b0, 9'(rx_level), 7'b0, 9'(tx_level)};
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      ctrl_q   <= '0;
      flags_q  <= '0;
      mask_q   <= '0;
      evt_q    <= '0;
      unf_q    <= 1'b0;
      err_q    <= 1'b0;
      flush_q  <= 1'b0;
    end else begin
      wb_ack_o <= acc;
      wb_dat_o <= rd ? rdata : '0;
      evt_q    <= irq_evt_i;
      // Set term is OR'ed last so a new edge beats a same-cycle W1C.
      flags_q  <= (flags_q & ~w1c) | (irq_evt_i & ~evt_q);
      mask_q   <= mask_nxt;
      flush_q  <= wr & (wb_adr_i == ADDR_CTRL) & wb_sel_i[0] & wb_dat_i[0];
      if (wr && wb_adr_i == ADDR_CTRL)
        ctrl_q <= (ctrl_q & ~lane_mask) | (wb_dat_i[15:0] & lane_mask);
      if (wr && wb_adr_i == ADDR_FSTAT) begin
        if (wb_dat_i[FSTAT_UNF]) unf_q <= 1'b0;
        if (wb_dat_i[FSTAT_ERR]) err_q <= 1'b0;
      end
      if (wr && wb_adr_i == ADDR_DATA && wb_sel_i != 4'hF) err_q <= 1'b1;
      if (rd && wb_adr_i == ADDR_DATA && rx_empty)         unf_q <= 1'b1;
    end
  end

  neosd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_tx_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .clear_i (flush_q),
    .push_i  (tx_push),
    .wdata_i (wb_dat_i),
    .pop_i   (tx_pop),
    .rdata_o (tx_data_o),
    .level_o (tx_level),
    .empty_o (tx_empty),
    .full_o  (tx_full)
  );

  neosd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_rx_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .clear_i (flush_q),
    .push_i  (rx_push),
    .wdata_i (rx_data_i),
    .pop_i   (rx_pop),
    .rdata_o (rx_head),
    .level_o (rx_level),
    .empty_o (rx_empty),
    .full_o  (rx_full)
  );

endmodule

// File: tb/tb_neosd_wbif.sv
// Directed self-checking bench for neosd_wbif (FIFO_DEPTH=8, NIRQ=5).
module tb_neosd_wbif;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [7:0]  adr = '0;
  logic [31:0] wdat = '0;
  logic [3:0]  sel = '0;
  logic        ack, stall;
  logic [31:0] rdat;
  logic [4:0]  irq_evt = '0;
  logic        irq;
  logic [15:0] ctrl;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] r;

  always #5 clk = ~clk;

  neosd_wbif #(.FIFO_DEPTH(8), .NIRQ(5)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_ack_o(ack), .wb_stall_o(stall), .wb_dat_o(rdat),
    .irq_evt_i(irq_evt), .irq_o(irq), .ctrl_o(ctrl),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One Wishbone access: drive at negedge, wait out stall (bounded),
  // accept on the next rising edge, sample ack/data 1ns later.
  task automatic wb_acc(input logic w, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] q);
    int unsigned n = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    #1;
    while (stall && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (stall) chk("stall_timeout", 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk("ack", 32'(ack), 32'd1);
    q = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; sel = '0;
  endtask

  task automatic wb_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    wb_acc(1'b1, a, d, s, dummy);
  endtask

  task automatic wb_rd(input logic [7:0] a, output logic [31:0] q);
    wb_acc(1'b0, a, '0, 4'hF, q);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_ctrl", 32'(ctrl), 32'd0);
    @(negedge clk); rstn = 1'b1;

    // INFO, then ack/data return to zero in the idle cycle
    wb_rd(8'h00, r);
    chk("info", r, 32'hE05D0320);
    @(posedge clk); #1;
    chk("ack_drop", 32'(ack), 32'd0);
    chk("dat_idle", rdat, 32'd0);

    // CTRL byte lanes
    wb_wr(8'h04, 32'h0000ABCD, 4'b0001);
    wb_rd(8'h04, r);
    chk("ctrl_lane0", r, 32'h000000CD);
    wb_wr(8'h04, 32'h0000AB00, 4'b0010);
    chk("ctrl_o_lane1", 32'(ctrl), 32'h0000ABCD);
    wb_wr(8'h04, 32'h0, 4'hF);
    chk("ctrl_clear", 32'(ctrl), 32'd0);

    // Unmapped address
    wb_wr(8'h20, 32'hFFFFFFFF, 4'hF);
    wb_rd(8'h20, r);
    chk("unmapped", r, 32'd0);

    // TX fill, stall on 9th write, release by one pop
    for (int i = 0; i < 8; i++) wb_wr(8'h10, 32'h10000000 + 32'(i), 4'hF);
    chk("tx_valid_full", 32'(tx_valid), 32'd1);
    chk("tx_head", tx_data, 32'h10000000);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h10; wdat = 32'h10000008; sel = 4'hF;
    #1 chk("stall_full", 32'(stall), 32'd1);
    @(negedge clk); #1;
    chk("stall_hold", 32'(stall), 32'd1);
    chk("no_ack_stalled", 32'(ack), 32'd0);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    chk("stall_drop", 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk("ack_9th", 32'(ack), 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; sel = '0;
    chk("tx_head2", tx_data, 32'h10000001);
    wb_rd(8'h14, r);
    chk("fstat_tx8", r, 32'h00000008);

    // Drain TX in order
    @(negedge clk); tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1 chk("tx_drain", tx_data, 32'h10000000 + 32'(i));
      @(negedge clk);
    end
    tx_ready = 1'b0;
    chk("tx_empty", 32'(tx_valid), 32'd0);

    // Partial DATA write sets ERR, W1C clears it
    wb_wr(8'h10, 32'hDEADBEEF, 4'b0011);
    wb_rd(8'h14, r);
    chk("fstat_err", r, 32'h80000000);
    wb_wr(8'h14, 32'h80000000, 4'hF);
    wb_rd(8'h14, r);
    chk("fstat_err_clr", r, 32'd0);

    // Underflow
    wb_rd(8'h10, r);
    chk("unf_data", r, 32'd0);
    wb_rd(8'h14, r);
    chk("fstat_unf", r, 32'h40000000);
    wb_wr(8'h14, 32'h40000000, 4'hF);
    wb_rd(8'h14, r);
    chk("fstat_unf_clr", r, 32'd0);

    // RX push 3, read back in order
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); rx_valid = 1'b1; rx_data = 32'hA5A50000 + 32'(i);
    end
    @(negedge clk); rx_valid = 1'b0; rx_data = '0;
    wb_rd(8'h14, r);
    chk("fstat_rx3", r, 32'h00030000);
    for (int i = 0; i < 3; i++) begin
      wb_rd(8'h10, r);
      chk("rx_word", r, 32'hA5A50000 + 32'(i));
    end
    wb_rd(8'h14, r);
    chk("fstat_rx0", r, 32'd0);

    // IRQ: set wins over same-cycle W1C
    wb_wr(8'h0C, 32'h1, 4'hF);
    wb_rd(8'h0C, r);
    chk("mask", r, 32'h1);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h08; wdat = 32'h1; sel = 4'hF;
    irq_evt = 5'b00001;
    @(posedge clk); #1;
    chk("ack_w1c", 32'(ack), 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; sel = '0;
    chk("irq_set_wins", 32'(irq), 32'd1);
    wb_rd(8'h08, r);
    chk("flags_set_wins", r, 32'h1);
    wb_wr(8'h08, 32'h1, 4'hF);
    chk("irq_cleared", 32'(irq), 32'd0);
    @(negedge clk); irq_evt = 5'b00011;
    @(posedge clk); #1;
    chk("irq_masked", 32'(irq), 32'd0);
    wb_rd(8'h08, r);
    chk("flags_bit1", r, 32'h2);
    wb_wr(8'h0C, 32'h3, 4'b0000);
    wb_rd(8'h0C, r);
    chk("mask_nosel", r, 32'h1);

    // CTRL.RST flush keeps FLAGS/MASK
    wb_wr(8'h10, 32'h11111111, 4'hF);
    wb_wr(8'h10, 32'h22222222, 4'hF);
    @(negedge clk); rx_valid = 1'b1; rx_data = 32'h33333333;
    @(negedge clk); rx_valid = 1'b0;
    wb_rd(8'h14, r);
    chk("fstat_pre_flush", r, 32'h00010002);
    wb_wr(8'h04, 32'h1, 4'b0001);
    @(posedge clk); #1;
    chk("flush_tx_valid", 32'(tx_valid), 32'd0);
    wb_rd(8'h14, r);
    chk("fstat_flushed", r, 32'd0);
    wb_rd(8'h0C, r);
    chk("mask_kept", r, 32'h1);
    wb_rd(8'h08, r);
    chk("flags_kept", r, 32'h2);
    wb_wr(8'h04, 32'h0, 4'hF);

    // Reset mid-transfer
    wb_wr(8'h10, 32'h44444444, 4'hF);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h00; sel = 4'hF;
    @(posedge clk); #1;
    chk("ack_before_rst", 32'(ack), 32'd1);
    rstn = 1'b0;
    #1;
    chk("rst_mid_ack", 32'(ack), 32'd0);
    chk("rst_mid_dat", rdat, 32'd0);
    chk("rst_mid_tx", 32'(tx_valid), 32'd0);
    cyc = 1'b0; stb = 1'b0; adr = '0; sel = '0;
    @(negedge clk); rstn = 1'b1;
    wb_rd(8'h14, r);
    chk("rst_mid_fstat", r, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/neosd_wbif.md
NEOSD_WBIF -- requirements
Module: neosd_wbif

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, depth of each data FIFO (power of two, 2..256).
REQ-002 SHALL have parameter NIRQ, default 5, number of interrupt sources (1..16).
REQ-003 SHALL have port clk_i, input, 1, clock, all logic on rising edge.
REQ-004 SHALL have port rstn_i, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have ports wb_cyc_i, wb_stb_i, wb_we_i, input, 1 each, Wishbone cycle, strobe and write.
REQ-006 SHALL have ports wb_adr_i (input, 8), wb_dat_i (input, 32) and wb_sel_i (input, 4), carrying address, write data and byte lanes.
REQ-007 SHALL have ports wb_ack_o (output, 1), wb_stall_o (output, 1) and wb_dat_o (output, 32), carrying acknowledge, pipelined stall and read data.
REQ-008 SHALL have port irq_evt_i, input, NIRQ, level status from SD FSMs; a rising edge raises the matching flag.
REQ-009 SHALL have port irq_o, output, 1, OR of (FLAGS & MASK).
REQ-010 SHALL have port ctrl_o, output, 16, CTRL register contents.
REQ-011 SHALL have ports tx_data_o (output, 32), tx_valid_o (output, 1) and tx_ready_i (input, 1), forming the TX FIFO read side toward the DAT FSM.
REQ-012 SHALL have ports rx_data_i (input, 32), rx_valid_i (input, 1) and rx_ready_o (output, 1), forming the RX FIFO write side from the DAT FSM.

Function
REQ-013 An access is accepted when wb_cyc_i & wb_stb_i & !wb_stall_o; wb_ack_o SHALL be 1 exactly one cycle after acceptance.
REQ-014 wb_dat_o SHALL be 0 in every cycle that does not follow an accepted read.
REQ-015 Register map: 0x00 INFO (read-only), 0x04 CTRL (read/write), 0x08 FLAGS (write-1-to-clear), 0x0C MASK (read/write), 0x10 DATA, 0x14 FSTAT; any other address SHALL read 0 and ignore writes.
REQ-016 INFO SHALL read [31:16]=0xE05D, [15:8]=log2(FIFO_DEPTH), [7:0]=0x20.
REQ-017 Writes to CTRL[15:0] and to MASK[NIRQ-1:0] SHALL update only the byte lanes whose wb_sel_i bit is set.
REQ-018 A flag SHALL set on a 0->1 transition of irq_evt_i[k], detected against a registered copy of the previous value.
REQ-019 If a flag set and a W1C to the same bit occur in the same cycle, the set SHALL win.
REQ-020 A DATA write with wb_sel_i=4'hF SHALL push wb_dat_i into the TX FIFO.
REQ-021 A DATA write with any other wb_sel_i value SHALL be acked, push nothing and set FSTAT.ERR.
REQ-022 wb_stall_o SHALL be 1 while the TX FIFO is full and wb_stb_i & wb_we_i address DATA, and 0 otherwise.
REQ-023 A DATA read SHALL pop the RX FIFO and return its head word.
REQ-024 A DATA read with the RX FIFO empty SHALL return 0, pop nothing and set FSTAT.UNF.
REQ-025 Both FIFOs SHALL be first-word-fall-through, with tx_valid_o = TX not empty and rx_ready_o = RX not full.
REQ-026 The TX FIFO SHALL pop on tx_valid_o & tx_ready_i; the RX FIFO SHALL push on rx_valid_i & rx_ready_o.
REQ-027 A simultaneous push and pop on a non-empty, non-full FIFO SHALL leave its level unchanged.
REQ-028 A simultaneous push and pop on an empty FIFO SHALL be treated as a push only.
REQ-029 FIFO pointers SHALL be log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH.
REQ-030 FIFO level counters SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-031 FSTAT SHALL read [8:0]=TX level, [24:16]=RX level, [30]=UNF, [31]=ERR; writing 1 to bit 30 or 31 SHALL clear that bit.
REQ-032 Writing 1 to CTRL bit 0 (RST) SHALL flush both FIFOs in the following cycle.
REQ-033 After a CTRL.RST flush, FLAGS and MASK SHALL be unchanged.
REQ-034 irq_o SHALL be registered-free combinational logic driven from flops only.

Reset
REQ-035 On rstn_i low, CTRL, FLAGS, MASK, FSTAT sticky bits, both FIFO pointers and levels, and the edge-detect registers SHALL all be 0.
REQ-036 On rstn_i low, wb_ack_o and wb_dat_o SHALL be 0, giving irq_o=0, tx_valid_o=0 and rx_ready_o=1.
REQ-037 Reset asserted mid-transfer SHALL drop any pending ack and discard all FIFO contents.

Structure
REQ-038 Package neosd_pkg SHALL hold the address constants, the INFO magic 0xE05D and the version 0x20.
REQ-039 A sub-module neosd_fifo (parameters DEPTH and WIDTH) SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-040 Reset, then read 0x00 -> 0xE05D0320 acked one cycle later.
REQ-041 Write CTRL=0x0000ABCD with wb_sel_i=4'b0001, then read -> 0x000000CD.
REQ-042 With tx_ready_i=0, write DATA 9 times (depth 8) -> 9th write stalls; pulse tx_ready_i -> stall drops, 9th word accepted; FSTAT[8:0]=8.
REQ-043 Read DATA with RX empty -> 0 returned; FSTAT bit30=1; write 0x40000000 to FSTAT -> bit30=0.
REQ-044 MASK=0x1; raise irq_evt_i[0] in the same cycle as a W1C of FLAGS bit0 -> flag stays 1, irq_o=1.
REQ-045 Push 3 words via rx_valid_i, read DATA 3 times -> same words in order; FSTAT[24:16]=0.
